// File: rtl/mux_input_sequencer.sv
// Upstream feeder for the six-input reordering priority mux.
// Collects channel samples over a valid/ready write port into a working bank.
// Once all six channels are fresh, the bank is snapshotted into a shadow bank
// that drives data0..data5, and sel is swept 0..5 one step per downstream
// handshake. The next frame may be written while a sweep runs.
module mux_input_sequencer #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [2:0]        wr_chan,
  input  logic [DATA_W-1:0] wr_data,
  output logic [2:0]        sel,
  output logic [DATA_W-1:0] data0,
  output logic [DATA_W-1:0] data1,
  output logic [DATA_W-1:0] data2,
  output logic [DATA_W-1:0] data3,
  output logic [DATA_W-1:0] data4,
  output logic [DATA_W-1:0] data5,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic              err
);

  // Parked select code: outside 0..5 so the mux output reads zero.
  localparam logic [2:0] SEL_PARK  = 3'b110;
  localparam logic [2:0] SEL_LAST  = 3'd5;
  localparam logic [2:0] CHAN_LIM  = 3'd6;
  localparam logic [5:0] MASK_FULL = 6'h3F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SWEEP = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [2:0]             step;
  logic [2:0]             step_nxt;
  logic [5:0]             mask;
  logic [5:0]             chan_onehot;
  logic [5:0][DATA_W-1:0] ch;
  logic [5:0][DATA_W-1:0] shadow;
  logic                   frame_full;
  logic                   wr_fire;
  logic                   wr_legal;
  logic                   snap;
  logic                   frame_done;

  // A complete pending frame blocks further writes until it is snapshotted.
  assign frame_full  = (mask == MASK_FULL);
  assign wr_ready    = ~frame_full;
  assign wr_fire     = wr_valid & wr_ready;
  assign wr_legal    = (wr_chan < CHAN_LIM);
  assign chan_onehot = 6'b000001 << wr_chan;

  assign data0 = shadow[0];
  assign data1 = shadow[1];
  assign data2 = shadow[2];
  assign data3 = shadow[3];
  assign data4 = shadow[4];
  assign data5 = shadow[5];

  // State register and sweep position.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      step  <= '0;
    end else begin
      state <= state_nxt;
      step  <= step_nxt;
    end
  end

  // Next-state logic and sweep-facing outputs.
  always_comb begin
    state_nxt  = state;
    step_nxt   = step;
    snap       = 1'b0;
    frame_done = 1'b0;
    out_valid  = 1'b0;
    sel        = SEL_PARK;
    busy       = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (frame_full) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        snap      = 1'b1;
        step_nxt  = '0;
        state_nxt = SWEEP;
      end
      SWEEP: begin
        out_valid = 1'b1;
        sel       = step;
        if (out_ready) begin
          if (step == SEL_LAST) begin
            frame_done = 1'b1;
            step_nxt   = '0;
            // A frame already waiting goes straight to LOAD: one gap cycle.
            state_nxt  = frame_full ? LOAD : IDLE;
          end else begin
            step_nxt = step + 3'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Working bank: legal writes overwrite the addressed channel.
  always_ff @(posedge clk) begin
    if (reset) begin
      ch <= '0;
    end else if (wr_fire && wr_legal) begin
      for (int i = 0; i < 6; i++) begin
        if (wr_chan == 3'(i)) begin
          ch[i] <= wr_data;
        end
      end
    end
  end

  // Freshness mask: cleared by the snapshot, which never coincides with a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask <= '0;
    end else if (snap) begin
      mask <= '0;
    end else if (wr_fire && wr_legal) begin
      mask <= mask | chan_onehot;
    end
  end

  // Shadow bank: only changes in LOAD, held through SWEEP and IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow <= '0;
    end else if (snap) begin
      shadow <= ch;
    end
  end

  // Completed-sweep counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (frame_done) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

  // Sticky illegal-channel flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if (wr_fire && !wr_legal) begin
      err <= 1'b1;
    end
  end

endmodule

// File: doc/mux_input_sequencer.md
# mux_input_sequencer

Upstream feeder for the six-input reordering priority mux. It collects 4-bit channel samples over a valid/ready write port and, once all six channels hold fresh data, snapshots them into a shadow bank that drives `data0`..`data5`. It then sweeps `sel` through 0..5, one step per downstream handshake. Writes for the next frame are accepted while a sweep is in progress (double-buffered). Between sweeps, `sel` parks at an invalid code so the mux output reads zero.

## Interface
- `DATA_W`, 4, channel sample width; must match the mux data width.
- `CNT_W`, 8, width of the completed-frame counter.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wr_valid`  in  1  write request.
- `wr_ready`  out  1  write accepted when `wr_valid && wr_ready`.
- `wr_chan`  in  3  target channel 0..5; 6 and 7 are illegal.
- `wr_data`  in  DATA_W  sample value.
- `sel`  out  3  mux select; 3'b110 when not sweeping.
- `data0`..`data5`  out  DATA_W each  shadow bank to the mux.
- `out_valid`  out  1  current `sel` is presented.
- `out_ready`  in  1  downstream consumed the current `sel` step.
- `busy`  out  1  state is not IDLE.
- `frame_cnt`  out  CNT_W  completed sweeps, wraps modulo 2^CNT_W.
- `err`  out  1  sticky flag: an illegal-channel write was accepted.

## Operation
- Channel bank `ch[0..5]` plus a 6-bit `mask` (bit set = channel written since last snapshot).
- Accepted write, `wr_chan` < 6:
  - `ch[wr_chan] <= wr_data`.
  - `mask[wr_chan] <= 1`.
  - Repeated writes to the same channel overwrite it; last value wins.
- Accepted write, `wr_chan` >= 6: data discarded, `mask` unchanged, `err <= 1`. Only reset clears `err`.
- `wr_ready = (mask != 6'h3F)`. A completed next frame stalls writes until it is snapshotted. `wr_ready` is independent of `wr_valid`.
- FSM states: IDLE, LOAD, SWEEP.
  - IDLE: `sel` = 3'b110, `out_valid` = 0. Go to LOAD when `mask` == 6'h3F.
  - LOAD (one cycle):
    - `data_i <= ch[i]` for all i.
    - `mask <= 0`; no write can coincide, because `wr_ready` = 0.
    - Next state SWEEP with `sel` = 0.
  - SWEEP: `out_valid` = 1, `sel` = k.
    - On `out_ready`: if k < 5, then k <= k+1.
    - On `out_ready` with k == 5: `frame_cnt <= frame_cnt + 1`; next state is LOAD if `mask` == 6'h3F at that edge, else IDLE.
    - Without `out_ready`: `sel` and the data outputs hold.
- `data0`..`data5` change only in LOAD. They hold their last snapshot through IDLE.
- `busy` = (state != IDLE).

## Timing
- Reset values: state IDLE, `sel` = 3'b110, `out_valid` = 0, `busy` = 0, `data0`..`data5` = 0, `ch` = 0, `mask` = 0, `wr_ready` = 1, `frame_cnt` = 0, `err` = 0.
- Latency, from the edge accepting the write that completes `mask` in IDLE (E0):
  - E1: state LOAD.
  - E2: `out_valid` = 1, `sel` = 0, new `data_i` visible.
- Sweep length: 6 handshakes minimum, i.e. 6 cycles with `out_ready` held high.
- Back-to-back frames: with the next frame complete before the final handshake, LOAD follows at the next edge. There is one non-valid cycle between sweeps; `sel` shows 3'b110 during LOAD.
- Writes during SWEEP or LOAD update `ch` and `mask` only. They never disturb the shadow outputs.
- Reset mid-sweep or mid-collection: all state returns to reset values on that edge, partial frames are discarded, and `out_valid` drops on the same edge.
- `frame_cnt` wraps from all-ones to 0 without error.

## Test plan
- Reset, then write ch0..5 = 1,2,3,4,5,6 back-to-back:
  - `out_valid` rises 2 edges after the 6th write.
  - With `out_ready` = 1, `sel` steps 0,1,2,3,4,5 on consecutive cycles with `data0`..`data5` = 1..6.
  - `frame_cnt` = 1 afterwards, then IDLE with `sel` = 3'b110.
- Backpressure: during a sweep, toggle `out_ready` 1,0,0,1. `sel` must hold during each low cycle and advance only on the high ones.
- Double buffer:
  - During a sweep, write all six channels with 9..14; `wr_ready` drops after the 6th write.
  - Shadow outputs stay at the old values until the final handshake.
  - LOAD follows immediately, and the next sweep presents 9..14.
- Overwrite and error:
  - Write ch2 = 7, then ch2 = 3, then `wr_chan` = 6 with data F, then the remaining channels.
  - Required: `data2` = 3, `err` = 1 and sticky, the chan-6 write does not count toward the frame.
- Reset mid-sweep with `sel` = 3: the next edge gives `out_valid` = 0, `sel` = 3'b110, `frame_cnt` = 0, `mask` cleared; a fresh 6-write frame restarts normally.
- Counter wrap: with `CNT_W` = 2, run 5 frames; `frame_cnt` reads 1,2,3,0,1.
